frame_stack_ctrl: RTL and testbench

Call-frame save/restore engine that sits on the far side of the 64 x 16-bit register file's function-call snapshot bus. On `push` it captures the 240-bit `fcOut` snapshot (15 registers x 16 bits) and writes it word by word into data memory. On `pop` it reads the most recent frame back, assembles it on `fcIn`, and pulses `restore` so the register file reloads those 15 registers. It owns the frame stack pointer (`depth`) and the memory handshake; the register file owns everything else.

---
 rtl/frame_stack_ctrl.sv | 158 +++++++++++++++
 tb/tb_frame_stack_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stack_ctrl.sv
// Call-frame save/restore engine: spills a 15-word register snapshot to data
// memory on push and reloads the most recent frame into the register file on pop.
module frame_stack_ctrl #(
    parameter int          WORD       = 16,
    parameter int          NREGS      = 15,
    parameter logic [15:0] BASE_ADDR  = 16'h8000,
    parameter int          MAX_FRAMES = 8,
    parameter int          DW         = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WORD*NREGS-1:0] fcOut,
    output logic [WORD*NREGS-1:0] fcIn,
    output logic                  restore,
    output logic                  busy,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DW-1:0]         depth,
    output logic [15:0]           mem_addr,
    output logic [WORD-1:0]       mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [WORD-1:0]       mem_rdata,
    input  logic                  mem_ready
);

    typedef enum logic [1:0] {IDLE, SAVE, LOAD, RESTORE} state_t;

    localparam logic [3:0]    LAST_IDX = 4'(NREGS - 1);
    localparam logic [DW-1:0] FULL     = DW'(MAX_FRAMES);

    state_t          state_reg, state_next;
    logic [3:0]      idx_reg, idx_next;
    logic [DW-1:0]   depth_reg, depth_next;
    logic [WORD-1:0] shadow_reg [NREGS];
    logic [WORD-1:0] fcin_reg   [NREGS];
    logic            overflow_reg, overflow_next;
    logic            underflow_reg, underflow_next;
    logic            capture;
    logic            load_word;
    logic            last_word;
    logic [15:0]     frame_num;

    assign last_word = (idx_reg == LAST_IDX);
    assign load_word = (state_reg == LOAD) && mem_ready;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        depth_next     = depth_reg;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        capture        = 1'b0;
        restore        = 1'b0;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        mem_addr       = 16'h0000;
        mem_wdata      = '0;
        frame_num      = 16'(depth_reg);
        case (state_reg)
            IDLE: begin
                // push has priority; a pop arriving with it is dropped
                if (push) begin
                    if (depth_reg == FULL) begin
                        overflow_next = 1'b1;
                    end else begin
                        capture    = 1'b1;
                        idx_next   = 4'd0;
                        state_next = SAVE;
                    end
                end else if (pop) begin
                    if (depth_reg == '0) begin
                        underflow_next = 1'b1;
                    end else begin
                        idx_next   = 4'd0;
                        state_next = LOAD;
                    end
                end
            end
            SAVE: begin
                mem_we    = 1'b1;
                mem_addr  = BASE_ADDR + frame_num * 16'(NREGS) + 16'(idx_reg);
                mem_wdata = shadow_reg[idx_reg];
                if (mem_ready) begin
                    idx_next = idx_reg + 4'd1;
                    if (last_word) begin
                        depth_next = depth_reg + 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            LOAD: begin
                // top of stack lives one frame below the current depth
                frame_num = 16'(depth_reg) - 16'd1;
                mem_re    = 1'b1;
                mem_addr  = BASE_ADDR + frame_num * 16'(NREGS) + 16'(idx_reg);
                if (mem_ready) begin
                    idx_next = idx_reg + 4'd1;
                    if (last_word) begin
                        depth_next = depth_reg - 1'b1;
                        state_next = RESTORE;
                    end
                end
            end
            RESTORE: begin
                restore    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            idx_reg       <= 4'd0;
            depth_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            depth_reg     <= depth_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reset) begin
                shadow_reg[i] <= '0;
                fcin_reg[i]   <= '0;
            end else begin
                if (capture) begin
                    shadow_reg[i] <= fcOut[i*WORD +: WORD];
                end
                if (load_word && (idx_reg == 4'(i))) begin
                    fcin_reg[i] <= mem_rdata;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_fcin
            assign fcIn[gi*WORD +: WORD] = fcin_reg[gi];
        end
    endgenerate

    assign busy      = (state_reg != IDLE);
    assign depth     = depth_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_frame_stack_ctrl.sv
// Directed bench for frame_stack_ctrl: push/pop, stalls, bounds, request
// conflicts and reset during a save, against a simple word-addressed memory.
module tb_frame_stack_ctrl;

    logic           clk = 1'b0;
    logic           reset, push, pop;
    logic [239:0]   fcOut, fcIn;
    logic           restore, busy, overflow, underflow;
    logic [3:0]     depth;
    logic [15:0]    mem_addr, mem_wdata, mem_rdata;
    logic           mem_we, mem_re, mem_ready;

    logic [15:0]    mem [0:65535];
    logic [15:0]    wr_addr_q[$];
    logic [15:0]    wr_data_q[$];
    logic [15:0]    rd_addr_q[$];

    int             checks = 0;
    int             failures = 0;
    logic           stall_mode = 1'b0;

    frame_stack_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .fcOut     (fcOut),
        .fcIn      (fcIn),
        .restore   (restore),
        .busy      (busy),
        .overflow  (overflow),
        .underflow (underflow),
        .depth     (depth),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // mid-cycle monitor: a request with ready high completes at the next edge
    always @(negedge clk) begin
        if (mem_we && mem_ready) begin
            mem[mem_addr] <= mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (mem_re && mem_ready) begin
            rd_addr_q.push_back(mem_addr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_mode) mem_ready = ~mem_ready;
    endtask

    task automatic set_frame(input logic [15:0] base, output logic [239:0] frame);
        for (int i = 0; i < 15; i++) frame[i*16 +: 16] = base + 16'(i);
    endtask

    task automatic do_push(input logic with_pop, input int pop_at,
                           output int nbusy, output int wstart);
        logic        stalled;
        logic [15:0] sa, sd;
        stalled = 1'b0;
        sa = '0;
        sd = '0;
        wstart = wr_addr_q.size();
        push = 1'b1;
        pop  = with_pop;
        tick();
        push  = 1'b0;
        pop   = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 200) begin
            if (stalled) begin
                check("stall_addr", 256'(mem_addr), 256'(sa));
                check("stall_wdata", 256'(mem_wdata), 256'(sd));
            end
            stalled = stall_mode && !mem_ready;
            sa = mem_addr;
            sd = mem_wdata;
            nbusy++;
            pop = (nbusy == pop_at);
            tick();
        end
        pop = 1'b0;
        check("push_done_idle", 256'(busy), 256'(0));
        $display("push depth=%0d busy_cycles=%0d", depth, nbusy);
    endtask

    task automatic do_pop(output int nbusy, output int rcyc, output int rcount,
                          output int rstart);
        rstart = rd_addr_q.size();
        pop = 1'b1;
        tick();
        pop    = 1'b0;
        nbusy  = 0;
        rcyc   = 0;
        rcount = 0;
        while (busy && nbusy < 200) begin
            nbusy++;
            if (restore) begin
                rcount++;
                rcyc = nbusy;
            end
            tick();
        end
        check("pop_done_idle", 256'(busy), 256'(0));
        $display("pop depth=%0d busy_cycles=%0d restore_cycle=%0d", depth, nbusy, rcyc);
    endtask

    initial begin
        int nb, ws, rc, rn, rs, wcount, rcount0;
        logic [239:0] exp_frame, frame7;

        reset = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        fcOut = '0;
        mem_ready = 1'b1;
        frame7 = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_depth", 256'(depth), 256'(0));
        check("rst_fcin", 256'(fcIn), 256'(0));
        check("rst_restore", 256'(restore), 256'(0));
        check("rst_mem_we", 256'(mem_we), 256'(0));
        check("rst_mem_addr", 256'(mem_addr), 256'(0));
        check("rst_overflow", 256'(overflow), 256'(0));
        check("rst_underflow", 256'(underflow), 256'(0));

        // basic push of 1000..100E to frame 0
        set_frame(16'h1000, exp_frame);
        fcOut = exp_frame;
        do_push(1'b0, 0, nb, ws);
        check("push_busy_cycles", 256'(nb), 256'(15));
        check("push_nwrites", 256'(wr_addr_q.size() - ws), 256'(15));
        for (int k = 0; k < 15; k++) begin
            check("push_addr", 256'(wr_addr_q[ws+k]), 256'(16'h8000 + k));
            check("push_data", 256'(wr_data_q[ws+k]), 256'(16'h1000 + k));
        end
        check("push_depth", 256'(depth), 256'(1));
        fcOut = '0;

        do_pop(nb, rc, rn, rs);
        check("pop_busy_cycles", 256'(nb), 256'(16));
        check("pop_restore_cycle", 256'(rc), 256'(16));
        check("pop_restore_count", 256'(rn), 256'(1));
        check("pop_nreads", 256'(rd_addr_q.size() - rs), 256'(15));
        for (int k = 0; k < 15; k++)
            check("pop_addr", 256'(rd_addr_q[rs+k]), 256'(16'h8000 + k));
        check("pop_fcin", 256'(fcIn), 256'(exp_frame));
        check("pop_depth", 256'(depth), 256'(0));

        // alternate-cycle stalls during a save
        set_frame(16'h2000, exp_frame);
        fcOut = exp_frame;
        stall_mode = 1'b1;
        mem_ready = 1'b1;
        do_push(1'b0, 0, nb, ws);
        stall_mode = 1'b0;
        mem_ready = 1'b1;
        check("stall_busy_cycles", 256'(nb), 256'(30));
        check("stall_nwrites", 256'(wr_addr_q.size() - ws), 256'(15));
        check("stall_last_addr", 256'(wr_addr_q[ws+14]), 256'(16'h800E));
        check("stall_depth", 256'(depth), 256'(1));
        do_pop(nb, rc, rn, rs);
        check("stall_pop_fcin", 256'(fcIn), 256'(exp_frame));
        check("stall_pop_depth", 256'(depth), 256'(0));

        // pop on an empty stack
        rcount0 = rd_addr_q.size();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("uflow_pulse", 256'(underflow), 256'(1));
        check("uflow_busy", 256'(busy), 256'(0));
        check("uflow_mem_re", 256'(mem_re), 256'(0));
        tick();
        check("uflow_end", 256'(underflow), 256'(0));
        check("uflow_nreads", 256'(rd_addr_q.size()), 256'(rcount0));
        $display("underflow probe depth=%0d", depth);

        // fill the stack
        for (int f = 0; f < 8; f++) begin
            set_frame(16'h3000 + 16'(f*16), exp_frame);
            fcOut = exp_frame;
            if (f == 7) frame7 = exp_frame;
            do_push(1'b0, 0, nb, ws);
            check("fill_first_addr", 256'(wr_addr_q[ws]), 256'(16'h8000 + f*15));
        end
        check("fill_frame7_addr", 256'(wr_addr_q[ws]), 256'(16'h8069));
        check("fill_depth", 256'(depth), 256'(8));

        // push on a full stack
        wcount = wr_addr_q.size();
        push = 1'b1;
        tick();
        push = 1'b0;
        check("oflow_pulse", 256'(overflow), 256'(1));
        check("oflow_busy", 256'(busy), 256'(0));
        check("oflow_mem_we", 256'(mem_we), 256'(0));
        tick();
        check("oflow_end", 256'(overflow), 256'(0));
        check("oflow_depth", 256'(depth), 256'(8));
        check("oflow_nwrites", 256'(wr_addr_q.size()), 256'(wcount));
        $display("overflow probe depth=%0d", depth);

        // unwind to depth 1; the first pop returns frame 7
        for (int p = 0; p < 7; p++) begin
            do_pop(nb, rc, rn, rs);
            if (p == 0) begin
                check("unwind_fcin", 256'(fcIn), 256'(frame7));
                check("unwind_first_addr", 256'(rd_addr_q[rs]), 256'(16'h8069));
            end
        end
        check("unwind_depth", 256'(depth), 256'(1));

        // push+pop together, plus a pop pulse mid-save
        set_frame(16'h4000, exp_frame);
        fcOut = exp_frame;
        rcount0 = rd_addr_q.size();
        do_push(1'b1, 3, nb, ws);
        check("conflict_busy_cycles", 256'(nb), 256'(15));
        check("conflict_first_addr", 256'(wr_addr_q[ws]), 256'(16'h800F));
        check("conflict_depth", 256'(depth), 256'(2));
        tick();
        check("conflict_no_load", 256'(busy), 256'(0));
        check("conflict_nreads", 256'(rd_addr_q.size()), 256'(rcount0));

        // reset after five words of a save
        wcount = wr_addr_q.size();
        push = 1'b1;
        tick();
        push = 1'b0;
        repeat (5) tick();
        check("midrst_words", 256'(wr_addr_q.size() - wcount), 256'(5));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_mem_we", 256'(mem_we), 256'(0));
        check("midrst_depth", 256'(depth), 256'(0));
        check("midrst_restore", 256'(restore), 256'(0));
        $display("reset mid-save depth=%0d", depth);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
